pipe_add_sub: RTL and testbench



---
 rtl/pipe_add_sub_if.sv | 26 ++
 rtl/pipe_add_sub.sv | 101 ++++++++++
 tb/tb_pipe_add_sub.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_add_sub_if.sv
// Handshake bundle for pipe_add_sub: operand beat in, result beat with status flags out.
interface pipe_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit carry-chained slice per stage,
// operands skewed forward, result chunks de-skewed, status flags registered with the result.
module pipe_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          reset,
    pipe_add_sub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // vld_p[k] qualifies operand level k; vld_p[STAGES] is the output register
    logic [STAGES:0]  vld_p;
    logic [WIDTH-1:0] x_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] r_p   [STAGES];
    logic             c_p   [STAGES];

    logic [CHUNK:0]   sum_s [STAGES];
    logic [WIDTH-1:0] rnx_s [STAGES];

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             advance;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             ci);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Signed overflow: operands agree in sign but the wrapped result does not
    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] r);
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    assign advance      = !vld_p[STAGES] || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_s[k] = chunk_add(x_p[k][k*CHUNK +: CHUNK], b_p[k][k*CHUNK +: CHUNK], c_p[k]);
            rnx_s[k] = r_p[k];
            rnx_s[k][k*CHUNK +: CHUNK] = sum_s[k][CHUNK-1:0];
        end
    end

    // Level 0 captures the operands; level k+1 holds chunks 0..k of the sum
    always_ff @(posedge clk) begin
        if (advance) begin
            if (bus.in_valid) begin
                x_p[0] <= bus.x;
                b_p[0] <= bus.sub ? ~bus.y : bus.y;
                c_p[0] <= bus.sub;
                r_p[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (vld_p[k-1]) begin
                    x_p[k] <= x_p[k-1];
                    b_p[k] <= b_p[k-1];
                    r_p[k] <= rnx_s[k-1];
                    c_p[k] <= sum_s[k-1][CHUNK];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p <= {vld_p[STAGES-1:0], bus.in_valid};
        end
    end

    // Output stage: full word and flags, cleared on reset so no stale beat is visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (advance && vld_p[STAGES-1]) begin
            result_q   <= rnx_s[STAGES-1];
            carry_q    <= sum_s[STAGES-1][CHUNK];
            overflow_q <= signed_ovf(x_p[STAGES-1], b_p[STAGES-1], rnx_s[STAGES-1]);
            zero_q     <= ~|rnx_s[STAGES-1];
        end
    end

    assign bus.out_valid = vld_p[STAGES];
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: three chunkings (8, 32, 1) driven in parallel and
// scored against an arithmetic reference model.
module tb_pipe_add_sub;
    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ordy, sb;
    logic [31:0] xv, yv;

    int n_cmp = 0;
    int n_err = 0;

    pipe_add_sub_if #(.WIDTH(32)) i8  ();
    pipe_add_sub_if #(.WIDTH(32)) i32 ();
    pipe_add_sub_if #(.WIDTH(32)) i1  ();

    pipe_add_sub #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .reset(rst), .bus(i8.slave));
    pipe_add_sub #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .reset(rst), .bus(i32.slave));
    pipe_add_sub #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .reset(rst), .bus(i1.slave));

    always #5 clk = ~clk;

    assign i8.in_valid  = iv;   assign i8.x  = xv; assign i8.y  = yv; assign i8.sub  = sb; assign i8.out_ready  = ordy;
    assign i32.in_valid = iv;   assign i32.x = xv; assign i32.y = yv; assign i32.sub = sb; assign i32.out_ready = ordy;
    assign i1.in_valid  = iv;   assign i1.x  = xv; assign i1.y  = yv; assign i1.sub  = sb; assign i1.out_ready  = ordy;

    logic        ov [3];
    logic        ird[3];
    logic        cy [3];
    logic        of [3];
    logic        zr [3];
    logic [31:0] res[3];

    assign ov[0] = i8.out_valid;  assign ird[0] = i8.in_ready;  assign res[0] = i8.result;
    assign cy[0] = i8.carry;      assign of[0]  = i8.overflow;  assign zr[0]  = i8.zero;
    assign ov[1] = i32.out_valid; assign ird[1] = i32.in_ready; assign res[1] = i32.result;
    assign cy[1] = i32.carry;     assign of[1]  = i32.overflow; assign zr[1]  = i32.zero;
    assign ov[2] = i1.out_valid;  assign ird[2] = i1.in_ready;  assign res[2] = i1.result;
    assign cy[2] = i1.carry;      assign of[2]  = i1.overflow;  assign zr[2]  = i1.zero;

    int cw[3]  = '{8, 32, 1};
    int lat[3] = '{4, 1, 32};

    exp_t sbuf[3][1024];
    int   wp[3]  = '{0, 0, 0};
    int   rp[3]  = '{0, 0, 0};
    int   got[3] = '{0, 0, 0};

    // Reference: exact integer arithmetic, flags from the mathematical result
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        longint      sa, sbv, ex;
        logic [32:0] wide;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (s) begin
            e.r = a - b;
            e.c = (a >= b);
            ex  = sa - sbv;
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            e.r  = wide[31:0];
            e.c  = (wide > 33'h0_FFFF_FFFF);
            ex   = sa + sbv;
        end
        e.o = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: beats accepted by each instance must come out in order, once each
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 3; d++) rp[d] = wp[d];
            end else begin
                for (int d = 0; d < 3; d++) begin
                    if (ov[d] && ordy) begin
                        n_cmp++;
                        assert (rp[d] != wp[d])
                        else begin
                            n_err++;
                            $error("FAIL sb/c%0d/extra: observed=unexpected beat expected=none", cw[d]);
                        end
                        if (rp[d] != wp[d]) begin
                            e = sbuf[d][rp[d] % 1024];
                            rp[d]++;
                            got[d]++;
                            chk($sformatf("sb/c%0d/res", cw[d]), 64'(res[d]), 64'(e.r));
                            chk($sformatf("sb/c%0d/carry", cw[d]), 64'(cy[d]), 64'(e.c));
                            chk($sformatf("sb/c%0d/ovf", cw[d]), 64'(of[d]), 64'(e.o));
                            chk($sformatf("sb/c%0d/zero", cw[d]), 64'(zr[d]), 64'(e.z));
                        end
                    end
                    if (iv && ird[d]) begin
                        sbuf[d][wp[d] % 1024] = model(xv, yv, sb);
                        wp[d]++;
                    end
                end
            end
        end
    end

    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] er, input logic ec,
                           input logic eo, input logic ez);
        int seen[3];
        int at[3];
        for (int d = 0; d < 3; d++) begin
            seen[d] = 0;
            at[d]   = -1;
        end
        @(posedge clk); #1;
        iv = 1'b1; xv = a; yv = b; sb = s; ordy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    seen[d]++;
                    if (seen[d] == 1) begin
                        at[d] = e;
                        chk($sformatf("%s/c%0d/res", nm, cw[d]), 64'(res[d]), 64'(er));
                        chk($sformatf("%s/c%0d/carry", nm, cw[d]), 64'(cy[d]), 64'(ec));
                        chk($sformatf("%s/c%0d/ovf", nm, cw[d]), 64'(of[d]), 64'(eo));
                        chk($sformatf("%s/c%0d/zero", nm, cw[d]), 64'(zr[d]), 64'(ez));
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s/c%0d/latency", nm, cw[d]), 64'(at[d]), 64'(lat[d]));
            chk($sformatf("%s/c%0d/once", nm, cw[d]), 64'(seen[d]), 64'(1));
        end
    endtask

    initial begin
        logic [31:0] held;
        int          sent, base, stale;
        logic        newb;

        // Asynchronous reset before any clock edge
        rst = 1'b0; iv = 1'b0; ordy = 1'b1; sb = 1'b0; xv = '0; yv = '0;
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst/c%0d/out_valid", cw[d]), 64'(ov[d]), 64'(0));
            chk($sformatf("rst/c%0d/res", cw[d]), 64'(res[d]), 64'(0));
            chk($sformatf("rst/c%0d/flags", cw[d]), 64'({cy[d], of[d], zr[d]}), 64'(0));
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("rst/c%0d/in_ready", cw[d]), 64'(ird[d]), 64'(1));

        // Directed vectors across all chunkings
        run_one("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_one("add_7f_1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("add_ffff_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_5_5",    32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_80_1",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_3_4",    32'h0000_0003, 32'h0000_0004, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Six back-to-back beats with a three-cycle output stall
        base = got[0];
        sent = 0;
        newb = 1'b1;
        held = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            ordy = !(c >= 5 && c < 8);
            if (sent < 6) begin
                if (newb) begin
                    xv = $urandom; yv = $urandom; sb = 1'($urandom_range(0, 1));
                end
                iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            newb = iv && ird[0];
            if (newb) sent++;
            if (c >= 5 && c < 8) begin
                chk($sformatf("stall/c%0d/out_valid", c), 64'(ov[0]), 64'(1));
                chk($sformatf("stall/c%0d/in_ready", c), 64'(ird[0]), 64'(0));
                if (c == 5) held = res[0];
                else chk($sformatf("stall/c%0d/held", c), 64'(res[0]), 64'(held));
            end
            if (c == 8) chk("stall/resume_sent", 64'(sent), 64'(6));
        end
        chk("stall/count", 64'(got[0] - base), 64'(6));
        for (int d = 0; d < 3; d++)
            chk($sformatf("stall/c%0d/drained", cw[d]), 64'(wp[d] - rp[d]), 64'(0));

        // Random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            xv   = pick();
            yv   = pick();
            sb   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        iv = 1'b0; ordy = 1'b1;
        repeat (45) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("rand/c%0d/drained", cw[d]), 64'(wp[d] - rp[d]), 64'(0));

        // Reset with beats in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            iv = 1'b1; xv = $urandom | 32'h1; yv = $urandom; sb = 1'b0;
        end
        @(posedge clk); #1;
        iv = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst/c%0d/out_valid", cw[d]), 64'(ov[d]), 64'(0));
            chk($sformatf("midrst/c%0d/res", cw[d]), 64'(res[d]), 64'(0));
            chk($sformatf("midrst/c%0d/flags", cw[d]), 64'({cy[d], of[d], zr[d]}), 64'(0));
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("midrst/c%0d/in_ready", cw[d]), 64'(ird[d]), 64'(1));
        stale = 0;
        for (int e = 0; e < 50; e++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (ov[d]) stale++;
        end
        chk("midrst/stale_beats", 64'(stale), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
